ex_wb_stage: RTL
================

Name: ex_wb_stage

Overview:
- Execute stage plus EX/WB pipeline register, directly downstream of the ID/EX register.
- Consumes the latched operands, immediate, register codes and control bits, and resolves one-deep data hazards by forwarding from its own EX/WB register.
- Computes the ALU result and latches the result, destination and write enable at each rising clock edge.
- Drives the register-file write port and keeps status flags and a retired-instruction counter.

Parameters:
- DATA_W, 8, datapath width.
- ADDR_W, 3, register-code width (8 registers).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- read_data_1  in  DATA_W  operand A from ID/EX.
- read_data_2  in  DATA_W  operand B from ID/EX.
- gen_imm_data  in  DATA_W  immediate from ID/EX.
- instruction_code1  in  ADDR_W  destination and source-1 register code.
- instruction_code2  in  ADDR_W  source-2 register code.
- reg_write  in  1  instruction writes a register; 0 marks a bubble.
- alu_src  in  1  1 selects gen_imm_data as operand B.
- alu_op  in  1  0 = ADD, 1 = MOV (pass operand B).
- rf_write_en  out  1  register-file write enable.
- rf_write_addr  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- carry_flag  out  1  carry of the last retired ADD.
- zero_flag  out  1  last retired result was zero.
- retire_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs and internal registers go to 0, including rf_write_addr (never Z).
  - Reset takes effect mid-operation with no pending write surviving.
  - The first rising edge after release samples inputs normally.
- Forwarding operand A:
  - fwd_a = rf_write_en AND instruction_code1 equals rf_write_addr.
  - A = fwd_a ? rf_write_data : read_data_1.
- Forwarding operand B:
  - fwd_b = rf_write_en AND instruction_code2 equals rf_write_addr.
  - B_reg = fwd_b ? rf_write_data : read_data_2.
- Unknown codes: a code containing X or Z bits never matches, so no forward happens. The ID/EX register drives Z codes in reset.
- Operand B select: B = alu_src ? gen_imm_data : B_reg. The immediate path is never forwarded.
- ALU:
  - ADD: {c, r} = A + B, computed DATA_W+1 wide. Result is r; carry is c. Wrap-around, e.g. 0xFF + 0x01 gives r = 0x00 and c = 1.
  - MOV: r = B, c = 0.
- Latency: one cycle. Inputs sampled at edge N appear on the rf_write_* outputs after edge N.
- Every rising edge:
  - rf_write_en <= reg_write.
  - rf_write_addr <= instruction_code1.
  - rf_write_data <= r.
- When reg_write = 1, at the same edge:
  - carry_flag <= c.
  - zero_flag <= (r == 0).
  - retire_count <= retire_count + 1, wrapping from all-ones to 0.
- When reg_write = 0 (bubble):
  - Flags and count hold.
  - rf_write_data still latches r and is a don't-care for the register file.
- Back-to-back dependents:
  - Two consecutive writes to the same register: the second instruction sees the forwarded value.
  - Dependence distance 2 or more is resolved by register-file write-before-read, not by this block.
- Both sources match: A and B may both forward at once (e.g. ADD R3, R3).
- No stall or flush inputs: the stage advances every cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - Constants DATA_W, ADDR_W, CNT_W.
  - ALU_OP_ADD = 1'b0, ALU_OP_MOV = 1'b1.
  - Reset constants shared with the ID/EX register.
- Sub-module ex_alu: combinational; inputs A, B, alu_op; outputs r, c.
- Forwarding logic, operand muxes, registers and counter stay in ex_wb_stage.

Test Plan:
- Reset: hold reset = 0 and drive arbitrary inputs with clk toggling -> all outputs 0 and no increment. Release and apply ADD with A = 0x05, B = 0x03, reg_write = 1, code1 = 2 -> next cycle rf_write_en = 1, addr = 2, data = 0x08, carry = 0, zero = 0, retire_count = 1.
- Immediate overflow: A = 0xFF, imm = 0x01, alu_src = 1, ADD -> data = 0x00, carry = 1, zero = 1.
- MOV: imm = 0x2A, alu_src = 1, alu_op = 1 -> data = 0x2A, carry = 0.
- Forwarding:
  - MOV R1, 0x10, then ADD R1, R1 with stale read_data = 0x00 -> second result 0x20.
  - Bubble between them (reg_write = 0) -> no forward, result 0x00.
- Unknown codes: drive code1 = 3'bzzz with rf_write_en = 1 -> no forward, A = read_data_1.
- Counter wrap: preload 0xFFFE retirements, then retire 2 more -> retire_count = 0x0000; a bubble leaves count and flags unchanged.

Source files
------------

// File: rtl/ex_wb_stage_pkg.sv
// Shared pipeline constants, ALU opcodes and the EX/WB register bundle.
// Reset constants are common with the upstream ID/EX register.
package pipeline_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_MOV = 1'b1;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ex_wb_t;

    localparam logic [DATA_W-1:0] DATA_RST = '0;
    localparam logic [ADDR_W-1:0] ADDR_RST = '0;
    localparam logic [CNT_W-1:0]  CNT_RST  = '0;
    localparam ex_wb_t EX_WB_RST = '{
        en:   1'b0,
        addr: ADDR_RST,
        data: DATA_RST
    };

endpackage

// File: rtl/ex_wb_stage_if.sv
// ID/EX operand bundle in, register-file write port and status out.
// slave is the stage side, master is the upstream/observer side.
interface ex_wb_stage_if;
    import pipeline_pkg::*;

    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] gen_imm_data;
    logic [ADDR_W-1:0] instruction_code1;
    logic [ADDR_W-1:0] instruction_code2;
    logic              reg_write;
    logic              alu_src;
    logic              alu_op;

    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              carry_flag;
    logic              zero_flag;
    logic [CNT_W-1:0]  retire_count;

    modport slave (
        input  read_data_1, read_data_2, gen_imm_data,
        input  instruction_code1, instruction_code2,
        input  reg_write, alu_src, alu_op,
        output rf_write_en, rf_write_addr, rf_write_data,
        output carry_flag, zero_flag, retire_count
    );

    modport master (
        output read_data_1, read_data_2, gen_imm_data,
        output instruction_code1, instruction_code2,
        output reg_write, alu_src, alu_op,
        input  rf_write_en, rf_write_addr, rf_write_data,
        input  carry_flag, zero_flag, retire_count
    );

endinterface

// File: rtl/ex_wb_stage_alu.sv
// Combinational execute ALU: ADD with carry-out, or MOV of operand B.
// Sum is formed one bit wider so the top bit is the carry.
module ex_alu
    import pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              alu_op,
    output logic [DATA_W-1:0] r,
    output logic              c
);

    logic [DATA_W:0] sum;

    // Select the operation; MOV never produces a carry.
    always_comb begin
        sum = '0;
        unique case (alu_op)
            ALU_OP_ADD: sum = {1'b0, a} + {1'b0, b};
            ALU_OP_MOV: sum = {1'b0, b};
            default:    sum = '0;
        endcase
    end

    assign r = sum[DATA_W-1:0];
    assign c = sum[DATA_W];

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage with EX/WB register, one-deep forwarding from its own
// result register, status flags and a retired-instruction counter.
module ex_wb_stage
    import pipeline_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ex_wb_stage_if.slave  bus
);

    ex_wb_t            wb_q;
    logic              carry_q;
    logic              zero_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              fwd_a;
    logic              fwd_b;
    logic              codes_ok_a;
    logic              codes_ok_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_reg;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;

    // Undriven (Z) or unknown codes must never select the forward path.
    always_comb begin
        codes_ok_a = !$isunknown(bus.instruction_code1)
                  && !$isunknown(wb_q.addr);
        codes_ok_b = !$isunknown(bus.instruction_code2)
                  && !$isunknown(wb_q.addr);
        fwd_a = wb_q.en && codes_ok_a
             && (bus.instruction_code1 == wb_q.addr);
        fwd_b = wb_q.en && codes_ok_b
             && (bus.instruction_code2 == wb_q.addr);
    end

    // Operand muxes; the immediate bypasses forwarding entirely.
    always_comb begin
        op_a     = fwd_a ? wb_q.data : bus.read_data_1;
        op_b_reg = fwd_b ? wb_q.data : bus.read_data_2;
        op_b     = bus.alu_src ? bus.gen_imm_data : op_b_reg;
    end

    ex_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (bus.alu_op),
        .r      (alu_r),
        .c      (alu_c)
    );

    // EX/WB register every cycle; flags and count only on retirement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q    <= EX_WB_RST;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= CNT_RST;
        end else begin
            wb_q.en   <= bus.reg_write;
            wb_q.addr <= bus.instruction_code1;
            wb_q.data <= alu_r;
            if (bus.reg_write) begin
                carry_q <= alu_c;
                zero_q  <= (alu_r == '0);
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.rf_write_en   = wb_q.en;
    assign bus.rf_write_addr = wb_q.addr;
    assign bus.rf_write_data = wb_q.data;
    assign bus.carry_flag    = carry_q;
    assign bus.zero_flag     = zero_q;
    assign bus.retire_count  = cnt_q;

endmodule
